// File: rtl/kgp_flags_pkg.sv
// ---------------------------------------------------------------------------
// kgp_flags_pkg
// Constants shared by the flag register unit and the branch decision logic:
// flag vector width and bit positions, the pending-counter state encoding,
// and the branch opcode constants.
// ---------------------------------------------------------------------------
package kgp_flags_pkg;

    localparam int unsigned FLAG_W = 3;
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_S = 1;
    localparam int unsigned FLAG_C = 2;

    // Branch opcodes consumed by the branch decision logic
    localparam logic [5:0] OP_B    = 6'b101011;
    localparam logic [5:0] OP_BL   = 6'b101000;
    localparam logic [5:0] OP_BZ   = 6'b110001;
    localparam logic [5:0] OP_BNZ  = 6'b110010;
    localparam logic [5:0] OP_BLTZ = 6'b110000;
    localparam logic [5:0] OP_BCY  = 6'b101001;
    localparam logic [5:0] OP_BNCY = 6'b101010;

    typedef enum logic {
        PendIdle,
        PendWait
    } pend_state_e;

endpackage

// File: rtl/flag_register_unit_if.sv
// ---------------------------------------------------------------------------
// flag_register_unit_if
// Bundles the flag-write, call/return and flag-status signals of the flag
// register unit.
//   master : issuing side (drives wr_*/alu_*/push/pop, observes flags)
//   slave  : flag register unit
// ---------------------------------------------------------------------------
interface flag_register_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic              wr_issue;
    logic              wr_valid;
    logic [2:0]        wr_mask;     // {C,S,Z}
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              push;
    logic              pop;
    logic              fZero;
    logic              fSign;
    logic              fCarry;
    logic              flags_ready;
    logic              stk_full;
    logic              stk_empty;
    logic              err;

    modport master (
        output wr_issue, wr_valid, wr_mask, alu_result, alu_carry, push, pop,
        input  fZero, fSign, fCarry, flags_ready, stk_full, stk_empty, err
    );

    modport slave (
        input  wr_issue, wr_valid, wr_mask, alu_result, alu_carry, push, pop,
        output fZero, fSign, fCarry, flags_ready, stk_full, stk_empty, err
    );
endinterface

// File: rtl/flag_stack.sv
// ---------------------------------------------------------------------------
// flag_stack
// LIFO of WIDTH-bit entries, DEPTH deep (power of two, >= 2).
//   clk, rst     : clock, synchronous active-low reset (clears pointer)
//   i_push/i_pop : push i_data / pop top entry; both at once -> neither
//   i_data       : value to push
//   o_top        : current top entry (valid when !o_empty)
//   o_full/o_empty
//   o_pop_ok     : pop accepted this cycle
//   o_overflow   : push while full, o_underflow : pop while empty
//   o_conflict   : push and pop in the same cycle
// ---------------------------------------------------------------------------
module flag_stack #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_pop_ok,
    output logic             o_overflow,
    output logic             o_underflow,
    output logic             o_conflict
);
    localparam int unsigned AW = $clog2(DEPTH);

    // Pointer is one bit wider than the index so it can hold DEPTH
    logic [AW:0]      r_sp;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push_ok;
    logic [AW-1:0]    w_top_idx;

    assign o_full      = (r_sp == (AW+1)'(DEPTH));
    assign o_empty     = (r_sp == '0);
    assign w_push_ok   = i_push && !i_pop && !o_full;
    assign o_pop_ok    = i_pop && !i_push && !o_empty;
    assign o_overflow  = i_push && !i_pop && o_full;
    assign o_underflow = i_pop && !i_push && o_empty;
    assign o_conflict  = i_push && i_pop;

    assign w_top_idx = r_sp[AW-1:0] - AW'(1);
    assign o_top     = r_mem[w_top_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sp <= '0;
        end else if (w_push_ok) begin
            r_sp <= r_sp + (AW+1)'(1);
        end else if (o_pop_ok) begin
            r_sp <= r_sp - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_sp[AW-1:0]] <= i_data;
        end
    end
endmodule

// File: rtl/flag_register_unit.sv
// ---------------------------------------------------------------------------
// flag_register_unit
// Registers Zero/Sign/Carry from ALU results, tracks in-flight flag-writing
// ops (flags_ready) and saves/restores flags on call/return via flag_stack.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-low reset
//   bus  : flag_register_unit_if.slave (wr_issue, wr_valid, wr_mask,
//          alu_result, alu_carry, push, pop in; fZero, fSign, fCarry,
//          flags_ready, stk_full, stk_empty, err out)
// Build option: FLAG_BYPASS_EN -- flag outputs and flags_ready reflect a
// same-cycle wr_valid combinationally; register contents are unchanged.
// ---------------------------------------------------------------------------
module flag_register_unit
    import kgp_flags_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_PEND  = 3,
    parameter int unsigned STK_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    flag_register_unit_if.slave bus
);
    localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);

    logic [PEND_W-1:0] r_pend, w_pend_d;
    logic [FLAG_W-1:0] r_flags, w_flags_d, w_new_flags, w_base_flags;
    logic [FLAG_W-1:0] w_stk_top, w_out_flags;
    logic              r_err;
    logic              w_pend_err;
    logic              w_stk_full, w_stk_empty, w_pop_ok;
    logic              w_overflow, w_underflow, w_conflict;
    pend_state_e       w_pend_state;

    flag_stack #(
        .WIDTH (FLAG_W),
        .DEPTH (STK_DEPTH)
    ) u_stack (
        .clk         (clk),
        .rst         (rst),
        .i_push      (bus.push),
        .i_pop       (bus.pop),
        .i_data      (r_flags),
        .o_top       (w_stk_top),
        .o_full      (w_stk_full),
        .o_empty     (w_stk_empty),
        .o_pop_ok    (w_pop_ok),
        .o_overflow  (w_overflow),
        .o_underflow (w_underflow),
        .o_conflict  (w_conflict)
    );

    // Pending counter: issue and valid together cancel out
    always_comb begin
        w_pend_d   = r_pend;
        w_pend_err = 1'b0;
        case ({bus.wr_issue, bus.wr_valid})
            2'b10: begin
                if (r_pend == PEND_W'(MAX_PEND)) w_pend_err = 1'b1;
                else                             w_pend_d   = r_pend + PEND_W'(1);
            end
            2'b01: begin
                if (r_pend == '0) w_pend_err = 1'b1;
                else              w_pend_d   = r_pend - PEND_W'(1);
            end
            default: ;
        endcase
    end

    // Popped value is the base; masked ALU bits override it
    always_comb begin
        w_new_flags         = '0;
        w_new_flags[FLAG_Z] = (bus.alu_result == '0);
        w_new_flags[FLAG_S] = bus.alu_result[DATA_W-1];
        w_new_flags[FLAG_C] = bus.alu_carry;
        w_base_flags        = w_pop_ok ? w_stk_top : r_flags;
        for (int i = 0; i < FLAG_W; i++) begin
            w_flags_d[i] = (bus.wr_valid && bus.wr_mask[i]) ? w_new_flags[i] : w_base_flags[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend  <= '0;
            r_flags <= '0;
            r_err   <= 1'b0;
        end else begin
            r_pend  <= w_pend_d;
            r_flags <= w_flags_d;
            r_err   <= r_err | w_pend_err | w_overflow | w_underflow | w_conflict;
        end
    end

    assign w_pend_state = (r_pend == '0) ? PendIdle : PendWait;

`ifdef FLAG_BYPASS_EN
    assign w_out_flags     = bus.wr_valid ? w_flags_d : r_flags;
    assign bus.flags_ready = (w_pend_state == PendIdle) ||
                             ((r_pend == PEND_W'(1)) && bus.wr_valid && !bus.wr_issue);
`else
    assign w_out_flags     = r_flags;
    assign bus.flags_ready = (w_pend_state == PendIdle);
`endif

    assign bus.fZero     = w_out_flags[FLAG_Z];
    assign bus.fSign     = w_out_flags[FLAG_S];
    assign bus.fCarry    = w_out_flags[FLAG_C];
    assign bus.stk_full  = w_stk_full;
    assign bus.stk_empty = w_stk_empty;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_flag_register_unit.sv
// ---------------------------------------------------------------------------
// tb_flag_register_unit
// Directed vector table for flag_register_unit plus hand-written sequences
// for mid-operation reset and same-cycle bypass behaviour.
// ---------------------------------------------------------------------------
module tb_flag_register_unit;

    typedef struct {
        string       name;
        bit          do_rst;
        bit          iss;
        bit          val;
        logic [2:0]  mask;
        logic [31:0] res;
        bit          cy;
        bit          psh;
        bit          pp;
        logic [2:0]  exp_f;   // {C,S,Z}
        bit          rdy;
        bit          full;
        bit          emp;
        bit          err;
    } vec_t;

`ifdef FLAG_BYPASS_EN
    localparam logic EXP_BYP = 1'b1;
`else
    localparam logic EXP_BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    vec_t vq[$];

    flag_register_unit_if #(.DATA_W(32)) bus ();

    flag_register_unit #(
        .DATA_W    (32),
        .MAX_PEND  (3),
        .STK_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string name, bit do_rst, bit iss, bit val, logic [2:0] mask,
                                logic [31:0] res, bit cy, bit psh, bit pp, logic [2:0] exp_f,
                                bit rdy, bit full, bit emp, bit err);
        vec_t v;
        v.name = name; v.do_rst = do_rst; v.iss = iss; v.val = val; v.mask = mask;
        v.res = res; v.cy = cy; v.psh = psh; v.pp = pp; v.exp_f = exp_f;
        v.rdy = rdy; v.full = full; v.emp = emp; v.err = err;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        rst            = 1'b1;
        bus.wr_issue   = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_mask    = 3'b000;
        bus.alu_result = 32'h0;
        bus.alu_carry  = 1'b0;
        bus.push       = 1'b0;
        bus.pop        = 1'b0;
    endtask

    // Apply one cycle of inputs, return inputs to idle, then compare
    task automatic step(vec_t v);
        rst            = ~v.do_rst;
        bus.wr_issue   = v.iss;
        bus.wr_valid   = v.val;
        bus.wr_mask    = v.mask;
        bus.alu_result = v.res;
        bus.alu_carry  = v.cy;
        bus.push       = v.psh;
        bus.pop        = v.pp;
        @(posedge clk);
        #1;
        drive_idle();
        check(v.name,
              {25'd0, bus.fCarry, bus.fSign, bus.fZero, bus.flags_ready, bus.stk_full,
               bus.stk_empty, bus.err},
              {25'd0, v.exp_f, v.rdy, v.full, v.emp, v.err});
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        drive_idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check("reset_state",
              {25'd0, bus.fCarry, bus.fSign, bus.fZero, bus.flags_ready, bus.stk_full,
               bus.stk_empty, bus.err}, 32'b0001010);

        //               name          rst iss val mask    result        cy psh pp  {C,S,Z} rdy F E err
        // Latency and pending-counter saturation
        vq.push_back(mk("issue1",       0, 1, 0, 3'b000, 32'h0,          0, 0, 0, 3'b000, 0, 0, 1, 0));
        vq.push_back(mk("valid1",       0, 0, 1, 3'b111, 32'h0,          1, 0, 0, 3'b101, 1, 0, 1, 0));
        vq.push_back(mk("iss_a",        0, 1, 0, 3'b000, 32'h0,          0, 0, 0, 3'b101, 0, 0, 1, 0));
        vq.push_back(mk("iss_b",        0, 1, 0, 3'b000, 32'h0,          0, 0, 0, 3'b101, 0, 0, 1, 0));
        vq.push_back(mk("iss_c",        0, 1, 0, 3'b000, 32'h0,          0, 0, 0, 3'b101, 0, 0, 1, 0));
        vq.push_back(mk("iss_over",     0, 1, 0, 3'b000, 32'h0,          0, 0, 0, 3'b101, 0, 0, 1, 1));
        vq.push_back(mk("drain_a",      0, 0, 1, 3'b000, 32'h0,          0, 0, 0, 3'b101, 0, 0, 1, 1));
        vq.push_back(mk("drain_b",      0, 0, 1, 3'b000, 32'h0,          0, 0, 0, 3'b101, 0, 0, 1, 1));
        vq.push_back(mk("drain_c",      0, 0, 1, 3'b000, 32'h0,          0, 0, 0, 3'b101, 1, 0, 1, 1));
        vq.push_back(mk("rst_a",        1, 0, 0, 3'b000, 32'h0,          0, 0, 0, 3'b000, 1, 0, 1, 0));
        // Push / overwrite / pop restore
        vq.push_back(mk("b_iss",        0, 1, 0, 3'b000, 32'h0,          0, 0, 0, 3'b000, 0, 0, 1, 0));
        vq.push_back(mk("b_set_s",      0, 0, 1, 3'b111, 32'h8000_0001,  0, 0, 0, 3'b010, 1, 0, 1, 0));
        vq.push_back(mk("b_push",       0, 0, 0, 3'b000, 32'h0,          0, 1, 0, 3'b010, 1, 0, 0, 0));
        vq.push_back(mk("b_iss2",       0, 1, 0, 3'b000, 32'h0,          0, 0, 0, 3'b010, 0, 0, 0, 0));
        vq.push_back(mk("b_over",       0, 0, 1, 3'b111, 32'h0,          1, 0, 0, 3'b101, 1, 0, 0, 0));
        vq.push_back(mk("b_pop",        0, 0, 0, 3'b000, 32'h0,          0, 0, 1, 3'b010, 1, 0, 1, 0));
        // LIFO ordering, overflow and underflow
        vq.push_back(mk("c_push1",      0, 0, 0, 3'b000, 32'h0,          0, 1, 0, 3'b010, 1, 0, 0, 0));
        vq.push_back(mk("c_iss1",       0, 1, 0, 3'b000, 32'h0,          0, 0, 0, 3'b010, 0, 0, 0, 0));
        vq.push_back(mk("c_set_c",      0, 0, 1, 3'b100, 32'h1,          1, 0, 0, 3'b110, 1, 0, 0, 0));
        vq.push_back(mk("c_push2",      0, 0, 0, 3'b000, 32'h0,          0, 1, 0, 3'b110, 1, 0, 0, 0));
        vq.push_back(mk("c_iss2",       0, 1, 0, 3'b000, 32'h0,          0, 0, 0, 3'b110, 0, 0, 0, 0));
        vq.push_back(mk("c_set_z",      0, 0, 1, 3'b001, 32'h0,          0, 0, 0, 3'b111, 1, 0, 0, 0));
        vq.push_back(mk("c_push3",      0, 0, 0, 3'b000, 32'h0,          0, 1, 0, 3'b111, 1, 0, 0, 0));
        vq.push_back(mk("c_push4",      0, 0, 0, 3'b000, 32'h0,          0, 1, 0, 3'b111, 1, 1, 0, 0));
        vq.push_back(mk("c_push5_ovf",  0, 0, 0, 3'b000, 32'h0,          0, 1, 0, 3'b111, 1, 1, 0, 1));
        vq.push_back(mk("c_pop1",       0, 0, 0, 3'b000, 32'h0,          0, 0, 1, 3'b111, 1, 0, 0, 1));
        vq.push_back(mk("c_pop2",       0, 0, 0, 3'b000, 32'h0,          0, 0, 1, 3'b111, 1, 0, 0, 1));
        vq.push_back(mk("c_pop3",       0, 0, 0, 3'b000, 32'h0,          0, 0, 1, 3'b110, 1, 0, 0, 1));
        vq.push_back(mk("c_pop4",       0, 0, 0, 3'b000, 32'h0,          0, 0, 1, 3'b010, 1, 0, 1, 1));
        vq.push_back(mk("c_pop5_udf",   0, 0, 0, 3'b000, 32'h0,          0, 0, 1, 3'b010, 1, 0, 1, 1));
        vq.push_back(mk("rst_c",        1, 0, 0, 3'b000, 32'h0,          0, 0, 0, 3'b000, 1, 0, 1, 0));
        // Pop with simultaneous masked write
        vq.push_back(mk("d_iss1",       0, 1, 0, 3'b000, 32'h0,          0, 0, 0, 3'b000, 0, 0, 1, 0));
        vq.push_back(mk("d_set_sc",     0, 0, 1, 3'b111, 32'h8000_0000,  1, 0, 0, 3'b110, 1, 0, 1, 0));
        vq.push_back(mk("d_push",       0, 0, 0, 3'b000, 32'h0,          0, 1, 0, 3'b110, 1, 0, 0, 0));
        vq.push_back(mk("d_iss2",       0, 1, 0, 3'b000, 32'h0,          0, 0, 0, 3'b110, 0, 0, 0, 0));
        vq.push_back(mk("d_clear",      0, 0, 1, 3'b111, 32'h1,          0, 0, 0, 3'b000, 1, 0, 0, 0));
        vq.push_back(mk("d_iss3",       0, 1, 0, 3'b000, 32'h0,          0, 0, 0, 3'b000, 0, 0, 0, 0));
        vq.push_back(mk("d_pop_wr",     0, 0, 1, 3'b001, 32'h0,          0, 0, 1, 3'b111, 1, 0, 1, 0));
        // Push and pop together: both ignored, write still lands
        vq.push_back(mk("e_push",       0, 0, 0, 3'b000, 32'h0,          0, 1, 0, 3'b111, 1, 0, 0, 0));
        vq.push_back(mk("e_iss",        0, 1, 0, 3'b000, 32'h0,          0, 0, 0, 3'b111, 0, 0, 0, 0));
        vq.push_back(mk("e_pushpop",    0, 0, 1, 3'b010, 32'h0,          0, 1, 1, 3'b101, 1, 0, 0, 1));
        vq.push_back(mk("rst_e",        1, 0, 0, 3'b000, 32'h0,          0, 0, 0, 3'b000, 1, 0, 1, 0));
        // Stray writes and pops at idle
        vq.push_back(mk("f_valid_idle", 0, 0, 1, 3'b111, 32'h5,          1, 0, 0, 3'b100, 1, 0, 1, 1));
        vq.push_back(mk("rst_f",        1, 0, 0, 3'b000, 32'h0,          0, 0, 0, 3'b000, 1, 0, 1, 0));
        vq.push_back(mk("f_pop_empty",  0, 0, 0, 3'b000, 32'h0,          0, 0, 1, 3'b000, 1, 0, 1, 1));
        vq.push_back(mk("rst_g",        1, 0, 0, 3'b000, 32'h0,          0, 0, 0, 3'b000, 1, 0, 1, 0));

        foreach (vq[i]) step(vq[i]);

        // Mid-operation reset, then a late in-flight result
        step(mk("m_iss1",  0, 1, 0, 3'b000, 32'h0, 0, 0, 0, 3'b000, 0, 0, 1, 0));
        step(mk("m_iss2",  0, 1, 0, 3'b000, 32'h0, 0, 0, 0, 3'b000, 0, 0, 1, 0));
        step(mk("m_push",  0, 0, 0, 3'b000, 32'h0, 0, 1, 0, 3'b000, 0, 0, 0, 0));
        step(mk("m_rst",   1, 1, 0, 3'b000, 32'h0, 0, 1, 0, 3'b000, 1, 0, 1, 0));
        step(mk("m_late",  0, 0, 1, 3'b111, 32'h0, 0, 0, 0, 3'b001, 1, 0, 1, 1));
        step(mk("rst_m",   1, 0, 0, 3'b000, 32'h0, 0, 0, 0, 3'b000, 1, 0, 1, 0));

        // Same-cycle visibility of a sign write (bypass build only)
        step(mk("byp_iss", 0, 1, 0, 3'b000, 32'h0, 0, 0, 0, 3'b000, 0, 0, 1, 0));
        bus.wr_valid   = 1'b1;
        bus.wr_mask    = 3'b010;
        bus.alu_result = 32'h8000_0000;
        #2;
        check("byp_sign_same", {31'd0, bus.fSign}, {31'd0, EXP_BYP});
        check("byp_ready_same", {31'd0, bus.flags_ready}, {31'd0, EXP_BYP});
        @(posedge clk);
        #1;
        drive_idle();
        check("byp_sign_next", {31'd0, bus.fSign}, 32'd1);
        check("byp_ready_next", {31'd0, bus.flags_ready}, 32'd1);
        check("byp_zc_next", {30'd0, bus.fCarry, bus.fZero}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
